pc_gen: RTL and testbench



---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_gen.sv | 102 ++++++++++
 tb/tb_pc_gen.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter generator.
// Holds the fetch FSM state encoding, the instruction size and the alignment check.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int DEFAULT_XLEN = 32;
  localparam int INSTR_BYTES  = 4;

  // Returns the offending low address bits; all-zero means instruction aligned.
  function automatic logic [1:0] misalign_bits(input logic [1:0] addr_lsb);
    logic [1:0] mask;
    mask = 2'(INSTR_BYTES - 1);
    return addr_lsb & mask;
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator: boot delay, halt/resume control and prioritised
// trap/branch redirects, presented to fetch through a valid/ready handshake.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BOOT_WAIT    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            halt_req,
  input  logic            resume_req,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] fetch_pc_plus4,
  output logic            misalign_err,
  output logic            halted
);

  localparam int              CW        = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT) : 1;
  localparam logic [CW-1:0]   BOOT_LAST = CW'((BOOT_WAIT > 0) ? (BOOT_WAIT - 1) : 0);

  pc_state_e       state_reg, state_next;
  logic [CW-1:0]   boot_cnt_reg;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            misalign_reg, misalign_next;
  logic            sel_valid;
  logic [XLEN-1:0] sel_target;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= BOOT;
    else       state_reg <= state_next;
  end

  // Next-state logic; resume wins over a simultaneous halt while halted
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:    if (BOOT_WAIT == 0 || boot_cnt_reg == BOOT_LAST) state_next = RUN;
      RUN:     if (halt_req)   state_next = HALT;
      HALT:    if (resume_req) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Outputs are forced inactive while reset is held, whatever the current state
  always_comb begin
    fetch_valid = !reset && (state_reg == RUN);
    halted      = !reset && (state_reg == HALT);
  end

  always_ff @(posedge clk) begin
    if (reset)                  boot_cnt_reg <= '0;
    else if (state_reg == BOOT) boot_cnt_reg <= boot_cnt_reg + 1'b1;
  end

  assign fetch_pc_plus4 = pc_reg + XLEN'(INSTR_BYTES);

  // Next-PC mux: trap over redirect over sequential advance; only the winning target is checked
  always_comb begin
    pc_next       = pc_reg;
    misalign_next = 1'b0;
    sel_valid     = 1'b0;
    sel_target    = '0;
    if (state_reg != BOOT) begin
      if (trap_valid) begin
        sel_valid  = 1'b1;
        sel_target = trap_target;
      end else if (redirect_valid) begin
        sel_valid  = 1'b1;
        sel_target = redirect_target;
      end
    end
    if (sel_valid) begin
      if (misalign_bits(sel_target[1:0]) != 2'b00) misalign_next = 1'b1;
      else                                          pc_next       = sel_target;
    end else if (fetch_valid && fetch_ready) begin
      pc_next = fetch_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= RESET_VECTOR;
      misalign_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      misalign_reg <= misalign_next;
    end
  end

  assign fetch_pc     = pc_reg;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_pc_gen.sv
// Randomised bench for pc_gen: a cycle-level reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0100;
  localparam int          BW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_target = '0;
  logic        halt_req = 1'b0;
  logic        resume_req = 1'b0;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_plus4;
  logic        misalign_err;
  logic        halted;

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .BOOT_WAIT(BW)) dut (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .halt_req(halt_req), .resume_req(resume_req),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pc_plus4(fetch_pc_plus4),
    .misalign_err(misalign_err), .halted(halted)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  // Reference model: mode 0=booting, 1=running, 2=halted; boot counts down remaining cycles
  int          m_mode = 0;
  int          m_boot_left = 0;
  logic [31:0] m_pc = '0;
  logic        m_err = 1'b0;
  bit          m_init = 1'b0;

  always @(posedge clk) begin : model
    int          nmode;
    logic [31:0] npc;
    logic        nerr;
    logic [31:0] tgt;
    bit          take;
    nmode = m_mode;
    npc   = m_pc;
    nerr  = 1'b0;
    take  = 0;
    tgt   = '0;
    if (reset) begin
      nmode = 0;
      npc   = RV;
      m_boot_left <= BW;
      m_init <= 1'b1;
    end else if (m_mode == 0) begin
      if (m_boot_left <= 1) nmode = 1;
      m_boot_left <= m_boot_left - 1;
    end else begin
      if (trap_valid)          begin take = 1; tgt = trap_target;     end
      else if (redirect_valid) begin take = 1; tgt = redirect_target; end
      if (take) begin
        if (tgt % 4 != 0) nerr = 1'b1;
        else              npc  = tgt;
      end else if (m_mode == 1 && fetch_ready) begin
        npc = m_pc + 32'd4;
      end
      if (m_mode == 1 && halt_req)   nmode = 2;
      if (m_mode == 2 && resume_req) nmode = 1;
    end
    m_mode <= nmode;
    m_pc   <= npc;
    m_err  <= nerr;
  end

  // Per-cycle comparison, sampled mid-period
  always @(negedge clk) begin
    if (m_init) begin
      chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, !reset && m_mode == 1});
      chk("halted", {31'b0, halted}, {31'b0, !reset && m_mode == 2});
      chk("fetch_pc", fetch_pc, m_pc);
      chk("fetch_pc_plus4", fetch_pc_plus4, m_pc + 32'd4);
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle();
    fetch_ready = 0; redirect_valid = 0; trap_valid = 0; halt_req = 0; resume_req = 0;
  endtask

  initial begin
    logic [31:0] seq_exp [5];
    logic        seq_rdy [5];
    logic [31:0] r;
    seq_exp = '{32'h104, 32'h108, 32'h108, 32'h108, 32'h10C};
    seq_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // Boot
    idle();
    reset = 1;
    step(2);
    reset = 0;
    #1;
    chk("boot_pc", fetch_pc, 32'h100);
    chk("boot_err", {31'b0, misalign_err}, 32'd0);
    chk("boot_halted", {31'b0, halted}, 32'd0);
    for (int i = 0; i < BW; i++) begin
      chk($sformatf("boot_wait%0d", i), {31'b0, fetch_valid}, 32'd0);
      step(1);
    end
    chk("boot_done_valid", {31'b0, fetch_valid}, 32'd1);
    chk("boot_done_pc", fetch_pc, 32'h100);

    // Sequential advance and stalls
    for (int i = 0; i < 5; i++) begin
      fetch_ready = seq_rdy[i];
      step(1);
      chk($sformatf("seq%0d", i), fetch_pc, seq_exp[i]);
    end

    // Priority
    fetch_ready = 0;
    trap_valid = 1; trap_target = 32'h800;
    redirect_valid = 1; redirect_target = 32'h200;
    step(1);
    chk("prio_trap", fetch_pc, 32'h800);
    trap_valid = 0;
    step(1);
    chk("redirect_stalled", fetch_pc, 32'h200);
    redirect_valid = 0;

    // Misalignment
    redirect_valid = 1; redirect_target = 32'h202;
    step(1);
    chk("misalign_hold", fetch_pc, 32'h200);
    chk("misalign_pulse", {31'b0, misalign_err}, 32'd1);
    redirect_valid = 0;
    step(1);
    chk("misalign_clear", {31'b0, misalign_err}, 32'd0);
    redirect_valid = 1; trap_valid = 1; trap_target = 32'h800;
    step(1);
    chk("trap_over_misalign", fetch_pc, 32'h800);
    chk("trap_over_misalign_err", {31'b0, misalign_err}, 32'd0);
    idle();

    // Halt, redirect while halted, resume and wrap
    halt_req = 1;
    step(1);
    halt_req = 0;
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_valid", {31'b0, fetch_valid}, 32'd0);
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 0;
    chk("halt_redirect_stays", {31'b0, halted}, 32'd1);
    resume_req = 1; halt_req = 1;
    step(1);
    resume_req = 0; halt_req = 0;
    chk("resume_valid", {31'b0, fetch_valid}, 32'd1);
    chk("resume_pc", fetch_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", fetch_pc_plus4, 32'h0);
    fetch_ready = 1;
    step(1);
    chk("wrap_pc", fetch_pc, 32'h0);

    // Reset mid-handshake
    fetch_ready = 0; redirect_valid = 1; redirect_target = 32'h40;
    step(1);
    redirect_valid = 0;
    chk("pre_reset_pc", fetch_pc, 32'h40);
    reset = 1;
    step(1);
    reset = 0;
    #1;
    chk("mid_reset_pc", fetch_pc, RV);
    chk("mid_reset_valid", {31'b0, fetch_valid}, 32'd0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 249) == 0);
      fetch_ready    = ($urandom_range(0, 3) != 0);
      trap_valid     = ($urandom_range(0, 15) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      halt_req       = ($urandom_range(0, 19) == 0);
      resume_req     = ($urandom_range(0, 9) == 0);
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) r = 32'hFFFF_FFFC;
      redirect_target = r;
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      trap_target = r;
      step(1);
    end
    idle();
    reset = 0;
    step(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
